// File: rtl/spi_cmd_decoder_pkg.sv
// spi_pkg: shared state encoding, command-byte layout and helpers for the
// SPI command decoder (spi_cmd_decoder, spi_frame_timer, spi_cmd_decoder_if).
// No ports; constants and types only.
package spi_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, READ, DISCARD} cmd_state_t;

  // Command byte = {rw, addr}; rw=1 selects a read burst.
  localparam int CMD_RW_BIT = 7;
  localparam int DEF_DATA_W = 8;

  // Saturating 16-bit increment used by the optional error counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/spi_cmd_decoder_if.sv
// spi_cmd_decoder_if: byte input, register-file port and tx/status outputs of
// the SPI command decoder. master = decoder side, slave = receive stage plus
// register file. err_cnt exists only when SPI_CMD_ERR_CNT_EN is defined.
interface spi_cmd_decoder_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] byte_data;
  logic              byte_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] tx_byte;
  logic              tx_valid;
  logic              frame_err;

`ifdef SPI_CMD_ERR_CNT_EN
  logic [15:0]       err_cnt;

  modport master (
    input  byte_data, byte_valid, rd_data,
    output wr_en, wr_addr, wr_data, rd_en, rd_addr, tx_byte, tx_valid,
           frame_err, err_cnt
  );
  modport slave (
    output byte_data, byte_valid, rd_data,
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr, tx_byte, tx_valid,
           frame_err, err_cnt
  );
`else
  modport master (
    input  byte_data, byte_valid, rd_data,
    output wr_en, wr_addr, wr_data, rd_en, rd_addr, tx_byte, tx_valid,
           frame_err
  );
  modport slave (
    output byte_data, byte_valid, rd_data,
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr, tx_byte, tx_valid,
           frame_err
  );
`endif

endinterface

// File: rtl/spi_cmd_decoder_timer.sv
// spi_frame_timer: idle timer that ends a frame after TIMEOUT_CYCLES quiet cycles.
// Ports: clk_sys, rst (async, active-high), run (count enable), restart (reload
// to 0, wins over expiry), expired (pulse in the cycle the count hits the limit).
module spi_frame_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic run,
  input  logic restart,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!run || restart) begin
      cnt <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

  // The owner leaves the running state on expiry, which drops run and clears
  // the count, so this is a single-cycle pulse. A restart masks it.
  assign expired = run && !restart && (cnt == LAST);

endmodule

// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder: parses received bytes into {rw,addr} command + data burst with
// auto-incrementing address; drives register write/read strobes and returns
// read data as tx_byte/tx_valid. Frames end on idle timeout (no chip-select).
// Ports: clk_sys, rst (async, active-high), bus (spi_cmd_decoder_if.master).
// Optional: SPI_CMD_ERR_CNT_EN adds a saturating 16-bit err_cnt output.
module spi_cmd_decoder
  import spi_pkg::*;
#(
  parameter int ADDR_W         = 7,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MAX_BURST      = 16
) (
  input logic               clk_sys,
  input logic               rst,
  spi_cmd_decoder_if.master bus
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_FULL = BW'(MAX_BURST);

  cmd_state_t        state;
  logic              valid_q;
  logic              evt;
  logic              expired;
  logic [ADDR_W-1:0] addr_q;
  logic [BW-1:0]     burst_cnt;

  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              rd_en_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [DATA_W-1:0] tx_byte_q;
  logic              tx_valid_q;
  logic              frame_err_q;

  // byte_valid is a level that may be held for many cycles; only its rising
  // edge counts as a received byte.
  assign evt = bus.byte_valid & ~valid_q;

  spi_frame_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk_sys (clk_sys),
    .rst     (rst),
    .run     (state != IDLE),
    .restart (evt),
    .expired (expired)
  );

`ifdef SPI_CMD_ERR_CNT_EN
  logic [15:0] err_cnt_q;
  assign bus.err_cnt = err_cnt_q;
`endif

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      valid_q     <= 1'b0;
      addr_q      <= '0;
      burst_cnt   <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      tx_byte_q   <= '0;
      tx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef SPI_CMD_ERR_CNT_EN
      err_cnt_q   <= '0;
`endif
    end else begin
      valid_q    <= bus.byte_valid;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      // rd_data is combinational from the register file while rd_en is high,
      // so it is captured on the edge that ends the rd_en cycle.
      tx_valid_q <= rd_en_q;
      if (rd_en_q) tx_byte_q <= bus.rd_data;

      case (state)
        IDLE: begin
          if (evt) begin
            addr_q      <= bus.byte_data[ADDR_W-1:0];
            state       <= bus.byte_data[CMD_RW_BIT] ? READ : WRITE;
            frame_err_q <= 1'b0;
            burst_cnt   <= '0;
          end
        end
        WRITE, READ: begin
          if (evt) begin
            if (burst_cnt == BURST_FULL) begin
              state       <= DISCARD;
              frame_err_q <= 1'b1;
`ifdef SPI_CMD_ERR_CNT_EN
              err_cnt_q   <= sat_inc16(err_cnt_q);
`endif
            end else begin
              // Never exceeds BURST_FULL: the overflow byte diverts to DISCARD.
              burst_cnt <= burst_cnt + 1'b1;
              addr_q    <= addr_q + 1'b1;
              if (state == WRITE) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= addr_q;
                wr_data_q <= bus.byte_data;
              end else begin
                rd_en_q   <= 1'b1;
                rd_addr_q <= addr_q;
              end
            end
          end else if (expired) begin
            state <= IDLE;
`ifdef SPI_CMD_ERR_CNT_EN
            if (burst_cnt == '0) err_cnt_q <= sat_inc16(err_cnt_q);
`endif
          end
        end
        DISCARD: begin
          if (expired) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.tx_byte   = tx_byte_q;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Self-checking bench for spi_cmd_decoder: scoreboard queues of expected
// write/read strobes and tx bytes (with their expected cycle), checked by a
// negedge monitor; scenario tasks check state, frame_err and err_cnt inline.
module tb_spi_cmd_decoder;
  import spi_pkg::*;

  localparam int T      = 1024;
  localparam int K_NONE = 0;
  localparam int K_WR   = 1;
  localparam int K_RD   = 2;

  typedef struct packed {
    logic [6:0]  addr;
    logic [7:0]  data;
    logic [31:0] cyc;
  } exp_t;

  logic clk_sys = 1'b0;
  logic rst;
  int   cyc       = 0;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  exp_t exp_wr[$];
  exp_t exp_rd[$];
  exp_t exp_tx[$];

  spi_cmd_decoder_if #(.ADDR_W(7), .DATA_W(8)) bif ();

  spi_cmd_decoder #(
    .ADDR_W(7), .DATA_W(8), .TIMEOUT_CYCLES(T), .MAX_BURST(16)
  ) dut (
    .clk_sys (clk_sys),
    .rst     (rst),
    .bus     (bif)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc = cyc + 1;

  // Register file model: every address reads back as addr + 1.
  assign bif.rd_data = {1'b0, bif.rd_addr} + 8'd1;

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk_sys) begin
    exp_t e;
    if (!rst) begin
      if (bif.wr_en && bif.rd_en) begin
        total_cnt++;
        $display("FAIL strobe_overlap got wr_en=1 rd_en=1 at cycle %0d, required at most one", cyc);
      end
      if (bif.wr_en) begin
        total_cnt++;
        if (exp_wr.size() == 0) begin
          $display("FAIL wr_unexpected got addr=%h data=%h cycle %0d, required no write", bif.wr_addr, bif.wr_data, cyc);
        end else begin
          e = exp_wr.pop_front();
          if ({bif.wr_addr, bif.wr_data, 32'(cyc)} !== {e.addr, e.data, e.cyc})
            $display("FAIL wr got addr=%h data=%h cycle %0d, required addr=%h data=%h cycle %0d",
                     bif.wr_addr, bif.wr_data, cyc, e.addr, e.data, e.cyc);
          else pass_cnt++;
        end
      end
      if (bif.rd_en) begin
        total_cnt++;
        if (exp_rd.size() == 0) begin
          $display("FAIL rd_unexpected got addr=%h cycle %0d, required no read", bif.rd_addr, cyc);
        end else begin
          e = exp_rd.pop_front();
          if ({bif.rd_addr, 32'(cyc)} !== {e.addr, e.cyc})
            $display("FAIL rd got addr=%h cycle %0d, required addr=%h cycle %0d", bif.rd_addr, cyc, e.addr, e.cyc);
          else pass_cnt++;
        end
      end
      if (bif.tx_valid) begin
        total_cnt++;
        if (exp_tx.size() == 0) begin
          $display("FAIL tx_unexpected got byte=%h cycle %0d, required no tx", bif.tx_byte, cyc);
        end else begin
          e = exp_tx.pop_front();
          if ({bif.tx_byte, 32'(cyc)} !== {e.data, e.cyc})
            $display("FAIL tx got byte=%h cycle %0d, required byte=%h cycle %0d", bif.tx_byte, cyc, e.data, e.cyc);
          else pass_cnt++;
        end
      end
    end
  end

  // Presents one byte, held for 'hold' cycles then low for one cycle, and
  // queues the strobe it should produce. k = cycle count when driven.
  task automatic send_byte(input logic [7:0] b, input int hold, input int kind,
                           input logic [6:0] a, output int k);
    exp_t e;
    @(negedge clk_sys);
    k = cyc;
    if (kind == K_WR) begin
      e.addr = a; e.data = b; e.cyc = 32'(k + 1);
      exp_wr.push_back(e);
    end else if (kind == K_RD) begin
      e.addr = a; e.data = 8'h00; e.cyc = 32'(k + 1);
      exp_rd.push_back(e);
      e.data = {1'b0, a} + 8'd1; e.cyc = 32'(k + 2);
      exp_tx.push_back(e);
    end
    bif.byte_data  = b;
    bif.byte_valid = 1'b1;
    repeat (hold) @(negedge clk_sys);
    bif.byte_valid = 1'b0;
    bif.byte_data  = 8'h00;
    @(negedge clk_sys);
  endtask

  task automatic wait_idle();
    repeat (T + 8) @(negedge clk_sys);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_sys);
    total_cnt++;
    if ({bif.wr_en, bif.rd_en, bif.tx_valid, bif.frame_err} !== 4'b0000)
      $display("FAIL reset_strobes got %b, required 0000", {bif.wr_en, bif.rd_en, bif.tx_valid, bif.frame_err});
    else pass_cnt++;
    total_cnt++;
    if ({bif.wr_addr, bif.wr_data, bif.rd_addr, bif.tx_byte} !== 30'h0)
      $display("FAIL reset_buses got %h, required 0", {bif.wr_addr, bif.wr_data, bif.rd_addr, bif.tx_byte});
    else pass_cnt++;
    total_cnt++;
    if (dut.state !== IDLE) $display("FAIL reset_state got %0d, required IDLE", dut.state);
    else pass_cnt++;
`ifdef SPI_CMD_ERR_CNT_EN
    total_cnt++;
    if (bif.err_cnt !== 16'h0) $display("FAIL reset_err_cnt got %h, required 0", bif.err_cnt);
    else pass_cnt++;
`endif
    rst = 1'b0;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic test_write();
    int k;
    send_byte(8'h05, 1, K_NONE, 7'h00, k);
    send_byte(8'hAA, 1, K_WR,   7'h05, k);
    send_byte(8'hBB, 1, K_WR,   7'h06, k);
    // Frame must survive exactly TIMEOUT_CYCLES-1 idle counts, then close.
    while (cyc < k + T) @(negedge clk_sys);
    total_cnt++;
    if (dut.state !== WRITE) $display("FAIL timeout_early got state %0d, required WRITE", dut.state);
    else pass_cnt++;
    @(negedge clk_sys);
    total_cnt++;
    if (dut.state !== IDLE) $display("FAIL timeout_late got state %0d, required IDLE", dut.state);
    else pass_cnt++;
    total_cnt++;
    if (exp_wr.size() != 0) $display("FAIL write_missing got %0d pending, required 0", exp_wr.size());
    else pass_cnt++;
  endtask

  task automatic test_read();
    int k;
    send_byte(8'h90, 1, K_NONE, 7'h00, k);
    send_byte(8'h5A, 1, K_RD,   7'h10, k);
    send_byte(8'hC3, 1, K_RD,   7'h11, k);
    wait_idle();
    total_cnt++;
    if (exp_rd.size() + exp_tx.size() != 0)
      $display("FAIL read_missing got %0d pending, required 0", exp_rd.size() + exp_tx.size());
    else pass_cnt++;
  endtask

  task automatic test_hold();
    int k;
    send_byte(8'h20, 5, K_NONE, 7'h00, k);
    for (int i = 0; i < 3; i++) send_byte(8'(i + 1), 5, K_WR, 7'(8'h20 + i), k);
    wait_idle();
    total_cnt++;
    if (exp_wr.size() != 0) $display("FAIL hold_missing got %0d pending, required 0", exp_wr.size());
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    int k;
    send_byte(8'h7F, 1, K_NONE, 7'h00, k);
    send_byte(8'h11, 1, K_WR,   7'h7F, k);
    send_byte(8'h22, 1, K_WR,   7'h00, k);
    wait_idle();
    total_cnt++;
    if (exp_wr.size() != 0) $display("FAIL wrap_missing got %0d pending, required 0", exp_wr.size());
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    int k;
    send_byte(8'h00, 1, K_NONE, 7'h00, k);
    for (int i = 0; i < 16; i++) send_byte(8'(8'h30 + i), 1, K_WR, 7'(i), k);
    send_byte(8'hEE, 1, K_NONE, 7'h00, k);
    total_cnt++;
    if (bif.frame_err !== 1'b1) $display("FAIL overflow_err got %b, required 1", bif.frame_err);
    else pass_cnt++;
    total_cnt++;
    if (dut.state !== DISCARD) $display("FAIL overflow_state got %0d, required DISCARD", dut.state);
    else pass_cnt++;
`ifdef SPI_CMD_ERR_CNT_EN
    total_cnt++;
    if (bif.err_cnt !== 16'd1) $display("FAIL err_cnt_overflow got %0d, required 1", bif.err_cnt);
    else pass_cnt++;
`endif
    wait_idle();
    total_cnt++;
    if ({dut.state == IDLE, bif.frame_err} !== 2'b11)
      $display("FAIL overflow_sticky got idle=%b err=%b, required idle=1 err=1", dut.state == IDLE, bif.frame_err);
    else pass_cnt++;
    send_byte(8'h03, 1, K_NONE, 7'h00, k);
    total_cnt++;
    if (bif.frame_err !== 1'b0) $display("FAIL err_clear got %b, required 0", bif.frame_err);
    else pass_cnt++;
    wait_idle();
`ifdef SPI_CMD_ERR_CNT_EN
    total_cnt++;
    if (bif.err_cnt !== 16'd2) $display("FAIL err_cnt_empty got %0d, required 2", bif.err_cnt);
    else pass_cnt++;
`endif
    total_cnt++;
    if (exp_wr.size() != 0) $display("FAIL overflow_missing got %0d pending, required 0", exp_wr.size());
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int k;
    send_byte(8'h40, 1, K_NONE, 7'h00, k);
    rst = 1'b1;
    repeat (2) @(negedge clk_sys);
    total_cnt++;
    if (dut.state !== IDLE) $display("FAIL midreset_state got %0d, required IDLE", dut.state);
    else pass_cnt++;
    rst = 1'b0;
    repeat (20) @(negedge clk_sys);
    send_byte(8'h01, 1, K_NONE, 7'h00, k);
    send_byte(8'h22, 1, K_WR,   7'h01, k);
    wait_idle();
    total_cnt++;
    if (exp_wr.size() != 0) $display("FAIL midreset_missing got %0d pending, required 0", exp_wr.size());
    else pass_cnt++;
  endtask

  initial begin
    rst            = 1'b1;
    bif.byte_valid = 1'b0;
    bif.byte_data  = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_hold();
    test_wrap();
    test_overflow();
    test_reset_mid();
    total_cnt++;
    if (exp_wr.size() + exp_rd.size() + exp_tx.size() != 0)
      $display("FAIL final_queues got %0d pending, required 0", exp_wr.size() + exp_rd.size() + exp_tx.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
